div_radix2: RTL and testbench

DIV_RADIX2 -- requirements
Module: div_radix2

---
 rtl/cpu_defs.sv | 5 +
 rtl/div_radix2.sv | 64 ++++++
 tb/tb_div_radix2.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared divider state encodings and iteration count
package cpu_defs;
  localparam int DIV_CYCLES = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, DIVZERO = 2'd1, DIVON = 2'd2, DONE = 2'd3} div_state_t;
endpackage

// File: rtl/div_radix2.sv
// div_radix2: radix-2 restoring DIV/DIVU (in: clk rst a b start signed_div annul; out: stall ready result={rem,quo})
module div_radix2
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);
  div_state_t  state, state_nxt;
  logic [5:0]  cnt;
  logic [64:0] pr, pr_nxt;
  logic [31:0] dvs, abs_a, abs_b, quo, rem;
  logic [33:0] diff;
  logic        sgn_div, sgn_a, sgn_b, last;
  assign abs_a = signed_div && a[31] ? -a : a;
  assign abs_b = signed_div && b[31] ? -b : b;
  assign last  = cnt == 6'(DIV_CYCLES - 1);
  assign diff  = pr[64:31] - {2'b0, dvs};
  assign pr_nxt = diff[33] ? {pr[63:0], 1'b0} : {diff[32:0], pr[30:0], 1'b1};
  assign quo   = sgn_div && (sgn_a ^ sgn_b) ? -pr_nxt[31:0] : pr_nxt[31:0];
  assign rem   = sgn_div && sgn_a ? -pr_nxt[63:32] : pr_nxt[63:32];
  always_comb begin
    state_nxt = annul ? IDLE :
                state == IDLE    ? (start ? (b == 32'd0 ? DIVZERO : DIVON) : IDLE) :
                state == DIVZERO ? DONE :
                state == DIVON   ? (last ? DONE : DIVON) : IDLE;
    stall = ~annul & ((state == IDLE & start) | state == DIVZERO | state == DIVON);
    ready = ~annul & state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pr      <= '0;
      dvs     <= '0;
      sgn_div <= 1'b0;
      sgn_a   <= 1'b0;
      sgn_b   <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == DIVON) begin
        cnt     <= '0;
        pr      <= {33'd0, abs_a};
        dvs     <= abs_b;
        sgn_div <= signed_div;
        sgn_a   <= a[31];
        sgn_b   <= b[31];
      end
      if (state == DIVON && !annul) begin
        pr  <= pr_nxt;
        cnt <= last ? 6'd0 : cnt + 6'd1;
      end
      if (state_nxt == DONE) result <= state == DIVZERO ? 64'd0 : {rem, quo};
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: randomized self-checking bench for div_radix2 against an arithmetic reference
module tb_div_radix2;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        stall, ready;
  logic [63:0] result, last_res;
  int          n_chk = 0, n_err = 0;
  div_radix2 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .signed_div(signed_div),
    .annul(annul), .stall(stall), .ready(ready), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    if (y == 32'd0) return 64'd0;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s, input logic keep, input string tag);
    int cyc = 0;
    logic ok = 1'b1;
    logic [63:0] exp = model(x, y, s);
    a = x; b = y; signed_div = s; start = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk({tag, "_hold"}, result, last_res);
        chk({tag, "_rdy0"}, 64'(ready), 64'd0);
      end
      if (ready) break;
      if (!stall) ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
      a = $urandom; b = $urandom;
    end
    chk({tag, "_lat"}, 64'(cyc), y == 32'd0 ? 64'd2 : 64'd33);
    chk({tag, "_stall_busy"}, 64'(ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    chk({tag, "_res"}, result, exp);
    last_res = exp;
    @(posedge clk); #1;
    start = keep;
    if (!keep) begin @(posedge clk); #1; end
  endtask
  task automatic quiet(input string tag);
    logic seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready || stall) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask
  initial begin
    last_res = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_div(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
    chk("u100_7_exact", last_res, {32'd2, 32'd14});
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, "s_m7_2");
    chk("s_m7_2_exact", last_res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_div(32'd5, 32'd0, 1'b0, 1'b0, "dz");
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(negedge clk);
    chk("ann_stall", 64'(stall), 64'd0);
    chk("ann_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    quiet("ann_quiet");
    do_div(32'd1000, 32'd33, 1'b0, 1'b0, "after_ann");
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    chk("ann_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    quiet("ann_start_quiet");
    do_div(32'd100, 32'd7, 1'b0, 1'b1, "b2b_1");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, "b2b_ovf");
    chk("ovf_exact", last_res, {32'd0, 32'h80000000});
    do_div(32'h80000000, 32'd3, 1'b1, 1'b1, "b2b_min");
    do_div(32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, "u_big");
    a = 32'd1000; b = 32'd3; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("mid_rst_result", result, 64'd0);
    @(posedge clk); #1;
    last_res = '0;
    quiet("mid_rst_quiet");
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = $urandom_range(1, 16);
        3: y = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom_range(1, 1000))};
        default: y = $urandom;
      endcase
      if (i % 5 == 0) x = 32'h80000000;
      do_div(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end
    start = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
